// File: rtl/mac_relu_accumulator.sv
// Streaming multiply-accumulate with saturating accumulator and ReLU output.
// Consumes a length-programmed stream of unsigned activation / signed weight
// pairs, accumulates their products, then presents max(acc, 0) on a
// valid/ready output together with a sticky saturation flag.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_start, i_len         start a vector of i_len pairs (sampled in IDLE)
//   i_x, i_w, i_x_valid    activation (unsigned), weight (signed), pair valid
//   o_x_ready              pair accepted this cycle
//   o_relu, o_sat          ReLU result and saturation flag, valid with o_valid
//   o_valid, i_ready       output handshake
//   o_busy                 block is not idle
module mac_relu_accumulator #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned LEN_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic [7:0]       i_x,
   input  logic [7:0]       i_w,
   input  logic             i_x_valid,
   output logic             o_x_ready,
   output logic [ACC_W-1:0] o_relu,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_sat,
   output logic             o_busy
);

   localparam int unsigned PROD_W = 17;
   localparam int unsigned SUM_W  = ACC_W + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

   state_t                   state;
   state_t                   next_state;

   logic [LEN_W-1:0]         len_q;
   logic [LEN_W-1:0]         cnt_q;
   logic signed [PROD_W-1:0] prod_q;
   logic                     prod_v_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     sat_q;

   logic                     start_c;
   logic                     beat_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [SUM_W-1:0]  addend_c;
   logic signed [SUM_W-1:0]  sum_c;
   logic                     clamp_c;
   logic signed [ACC_W-1:0]  final_c;

   // 9-bit signed activation times 8-bit signed weight always fits in 17 bits
   assign prod_c = PROD_W'($signed({1'b0, i_x})) * PROD_W'($signed(i_w));

   // Saturating add of the pending product; with no pending product the
   // addend is zero and the accumulator passes through unclamped.
   always_comb begin
      addend_c = '0;
      if (prod_v_q) addend_c = SUM_W'(prod_q);
      sum_c   = SUM_W'(acc_q) + addend_c;
      clamp_c = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
      final_c = sum_c[ACC_W-1:0];
      if (clamp_c) begin
         if (sum_c[SUM_W-1]) final_c = {1'b1, {(ACC_W-1){1'b0}}};
         else                final_c = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   // Next-state and control strobes
   always_comb begin
      next_state = state;
      start_c    = 1'b0;
      beat_c     = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               start_c    = 1'b1;
               next_state = (i_len != '0) ? ACCUM : DRAIN;
            end
         end
         ACCUM: begin
            beat_c = i_x_valid && o_x_ready;
            if (beat_c && (cnt_q + LEN_W'(1) == len_q)) next_state = DRAIN;
         end
         DRAIN:   next_state = OUTPUT;
         OUTPUT:  if (i_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= next_state;
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_x_ready <= 1'b0;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
         o_relu    <= '0;
         o_sat     <= 1'b0;
         len_q     <= '0;
         cnt_q     <= '0;
         prod_q    <= '0;
         prod_v_q  <= 1'b0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         // ACCUM is only ever occupied while count < len, so ready tracks the state
         o_x_ready <= (next_state == ACCUM);
         o_valid   <= (next_state == OUTPUT);
         o_busy    <= (next_state != IDLE);
         if (start_c) begin
            len_q    <= i_len;
            cnt_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
         end else if (state == ACCUM) begin
            prod_v_q <= beat_c;
            if (beat_c) begin
               prod_q <= prod_c;
               cnt_q  <= cnt_q + LEN_W'(1);
            end
            if (prod_v_q) begin
               acc_q <= final_c;
               sat_q <= sat_q | clamp_c;
            end
         end else if (state == DRAIN) begin
            acc_q    <= final_c;
            prod_v_q <= 1'b0;
            sat_q    <= sat_q | clamp_c;
            o_sat    <= sat_q | clamp_c;
            o_relu   <= final_c[ACC_W-1] ? '0 : $unsigned(final_c);
         end
      end
   end

endmodule

// File: tb/tb_mac_relu_accumulator.sv
// Bench for mac_relu_accumulator: a 32-bit and a 16-bit accumulator instance
// share one stimulus stream; results are compared against table constants and
// an arithmetic reference model.
module tb_mac_relu_accumulator;

   localparam int unsigned LEN_W = 16;

   typedef logic [63:0] u64_t;

   typedef struct packed {
      logic [3:0]      len;
      logic [3:0][7:0] x;
      logic [3:0][7:0] w;
      logic [3:0]      gap;
      logic [3:0]      hold;
      logic            pulse;
      logic [31:0]     e32;
      logic            s32;
      logic [15:0]     e16;
      logic            s16;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic [7:0]       x;
   logic [7:0]       w;
   logic             x_valid;
   logic             ready;
   logic             xr32, v32, s32, b32;
   logic             xr16, v16, s16, b16;
   logic [31:0]      r32;
   logic [15:0]      r16;

   int               errors = 0;
   int               checks = 0;
   logic [7:0]       vx[$];
   logic [7:0]       vw[$];
   vec_t             tbl[7];

   always #5 clk = ~clk;

   mac_relu_accumulator #(.ACC_W(32), .LEN_W(LEN_W)) u32 (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_len(len),
      .i_x(x), .i_w(w), .i_x_valid(x_valid), .o_x_ready(xr32),
      .o_relu(r32), .o_valid(v32), .i_ready(ready), .o_sat(s32), .o_busy(b32)
   );

   mac_relu_accumulator #(.ACC_W(16), .LEN_W(LEN_W)) u16 (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_len(len),
      .i_x(x), .i_w(w), .i_x_valid(x_valid), .o_x_ready(xr16),
      .o_relu(r16), .o_valid(v16), .i_ready(ready), .o_sat(s16), .o_busy(b16)
   );

   task automatic chk(input string name, input u64_t act, input u64_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Dot product of the queued pairs with a signed accumulator clamped to
   // 'width' bits after every product, followed by ReLU.
   task automatic model(input int width, output u64_t relu, output logic sat);
      longint acc, mx, mn;
      mx  = (longint'(1) <<< (width - 1)) - 1;
      mn  = -(longint'(1) <<< (width - 1));
      acc = 0;
      sat = 1'b0;
      foreach (vx[k]) begin
         acc += longint'(vx[k]) * longint'($signed(vw[k]));
         if (acc > mx) begin
            acc = mx; sat = 1'b1;
         end else if (acc < mn) begin
            acc = mn; sat = 1'b1;
         end
      end
      relu = (acc < 0) ? 64'd0 : u64_t'(acc);
   endtask

   function automatic vec_t mk(input int l, input logic [31:0] xs, input logic [31:0] ws,
                               input int gap, input int hold, input logic pulse,
                               input int e32, input logic es32, input int e16, input logic es16);
      vec_t v;
      v.len = 4'(l);  v.x = xs;  v.w = ws;
      v.gap = 4'(gap); v.hold = 4'(hold); v.pulse = pulse;
      v.e32 = 32'(e32); v.s32 = es32; v.e16 = 16'(e16); v.s16 = es16;
      return v;
   endfunction

   // Runs one full vector from the queues, checking handshake timing and results.
   task automatic run_vec(input int gap, input int hold, input logic pulse,
                          input u64_t e32, input logic es32, input u64_t e16, input logic es16);
      int n;
      int lat;
      int vlen;
      vlen = vx.size();
      @(negedge clk);
      start = 1'b1; len = LEN_W'(vlen); x_valid = 1'b0; ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start32", u64_t'(b32), 64'd1);
      chk("busy_after_start16", u64_t'(b16), 64'd1);
      chk("xready_after_start", u64_t'(xr32), u64_t'(vlen != 0));
      for (int k = 0; k < vlen; k++) begin
         if (k != 0) repeat (gap) @(negedge clk);
         x = vx[k]; w = vw[k]; x_valid = 1'b1;
         n = 0;
         while (!xr32 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!xr32) chk("beat_ready_timeout", u64_t'(xr32), 64'd1);
         @(negedge clk);
         x_valid = 1'b0;
      end
      lat = 1;
      while (!v32 && lat < 20) begin
         if (vlen == 0) chk("len0_xready", u64_t'(xr32), 64'd0);
         @(negedge clk);
         lat++;
      end
      chk("valid_latency", u64_t'(lat), 64'd2);
      chk("valid16", u64_t'(v16), 64'd1);
      chk("relu32", u64_t'(r32), e32);
      chk("sat32", u64_t'(s32), u64_t'(es32));
      chk("relu16", u64_t'(r16), e16);
      chk("sat16", u64_t'(s16), u64_t'(es16));
      for (int h = 0; h < hold; h++) begin
         start = pulse && (h == 0);
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid", u64_t'(v32), 64'd1);
         chk("hold_relu32", u64_t'(r32), e32);
         chk("hold_relu16", u64_t'(r16), e16);
         chk("hold_sat16", u64_t'(s16), u64_t'(es16));
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("valid_drop", u64_t'(v32), 64'd0);
      chk("busy_drop32", u64_t'(b32), 64'd0);
      chk("busy_drop16", u64_t'(b16), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      u64_t m32, m16;
      logic ms32, ms16;
      int   l;

      rst = 1'b1; start = 1'b0; len = '0; x = '0; w = '0; x_valid = 1'b0; ready = 1'b0;
      #1;
      chk("reset_xready", u64_t'(xr32), 64'd0);
      chk("reset_valid", u64_t'(v32), 64'd0);
      chk("reset_busy", u64_t'(b32), 64'd0);
      chk("reset_sat", u64_t'(s32), 64'd0);
      chk("reset_relu", u64_t'(r32), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      tbl[0] = mk(4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, 1'b0, 10, 1'b0, 10, 1'b0);
      tbl[1] = mk(2, {8'd0, 8'd0, 8'd3, 8'd10}, {8'd0, 8'd0, 8'd2, 8'hFB}, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      tbl[2] = mk(1, {8'd0, 8'd0, 8'd0, 8'd200}, {8'd0, 8'd0, 8'd0, 8'h80}, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      tbl[3] = mk(2, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd127, 8'd127}, 0, 0, 1'b0, 64770, 1'b0, 32767, 1'b1);
      tbl[4] = mk(2, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'h80, 8'h80}, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
      tbl[5] = mk(3, {8'd0, 8'd7, 8'd6, 8'd5}, {8'd0, 8'd2, 8'd2, 8'd2}, 2, 5, 1'b1, 36, 1'b0, 36, 1'b0);
      tbl[6] = mk(0, 32'd0, 32'd0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 7; i++) begin
         vx.delete(); vw.delete();
         for (int k = 0; k < int'(tbl[i].len); k++) begin
            vx.push_back(tbl[i].x[k]);
            vw.push_back(tbl[i].w[k]);
         end
         run_vec(int'(tbl[i].gap), int'(tbl[i].hold), tbl[i].pulse,
                 u64_t'(tbl[i].e32), tbl[i].s32, u64_t'(tbl[i].e16), tbl[i].s16);
      end

      for (int i = 0; i < 24; i++) begin
         vx.delete(); vw.delete();
         l = int'($urandom_range(0, 10));
         for (int k = 0; k < l; k++) begin
            vx.push_back(8'($urandom));
            vw.push_back(8'($urandom));
         end
         model(32, m32, ms32);
         model(16, m16, ms16);
         run_vec(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 m32, ms32, m16, ms16);
      end

      // Mid-vector reset after a vector that leaves a non-zero result behind
      vx = '{8'd100}; vw = '{8'd100};
      run_vec(0, 0, 1'b0, 64'd10000, 1'b0, 64'd10000, 1'b0);
      @(negedge clk);
      start = 1'b1; len = LEN_W'(8);
      @(negedge clk);
      start = 1'b0; x = 8'd50; w = 8'd100; x_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      x_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midreset_xready", u64_t'(xr32), 64'd0);
      chk("midreset_busy32", u64_t'(b32), 64'd0);
      chk("midreset_busy16", u64_t'(b16), 64'd0);
      chk("midreset_valid", u64_t'(v32), 64'd0);
      chk("midreset_relu32", u64_t'(r32), 64'd0);
      chk("midreset_relu16", u64_t'(r16), 64'd0);
      chk("midreset_sat", u64_t'(s32), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      vx = '{8'd9}; vw = '{8'd9};
      run_vec(0, 0, 1'b0, 64'd81, 1'b0, 64'd81, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
